// File: rtl/fir_mem_pkg.sv
// ============================================================================
// fir_mem_pkg : shared types, widths and saturation helper for fir_mem_master
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fir_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACC  = 3'd2,
    SUM  = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } state_t;

  // Clamp a sign-extended value into the signed 8-bit range.
  function automatic logic [DATA_W-1:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127) begin
      return 8'h7F;
    end else if (v < -32'sd128) begin
      return 8'h80;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac.sv
// ============================================================================
// fir_mac : signed 8x8 multiply-accumulate, product registered before summing
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_mac #(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [15:0] prod;
  logic               prod_vld;

  // The product of the last enabled cycle is folded in one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) begin
        prod <= 16'(a) * 16'(b);
      end
      if (prod_vld) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_mem_master.sv
// ============================================================================
// fir_mem_master : memory-side block FIR engine (coef load, MAC, write-back)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fir_mem_master
  import fir_mem_pkg::*;
#(
  parameter int               TAPS      = 4,
  parameter logic [ADDR_W-1:0] COEF_BASE = 8'd100,
  parameter int               SHIFT     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [7:0]        len,
  input  logic [DATA_W-1:0] readData,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  output logic              memRead,
  output logic              busy,
  output logic              done
);

  localparam int             K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int             ACC_W  = 16 + $clog2(TAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

  state_t state, state_nxt;

  logic [K_W-1:0]           k;
  logic [7:0]               n;
  logic [ADDR_W-1:0]        src;
  logic [ADDR_W-1:0]        dst;
  logic [7:0]               len_lat;
  logic signed [DATA_W-1:0] coef [TAPS];

  logic                     last_k;
  logic                     last_n;
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc;
  logic signed [31:0]       acc_wide;
  logic signed [31:0]       scaled;

  assign last_k   = (k == K_LAST);
  assign last_n   = (n == len_lat - 8'd1);
  assign acc_wide = 32'(acc);
  assign scaled   = acc_wide >>> SHIFT;

  assign mac_en  = (state == ACC);
  assign mac_clr = ((state == LOAD) && last_k) || (state == WR);

  fir_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (coef[k]),
    .b   ($signed(readData)),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == 8'd0) ? FIN : LOAD;
        end
      end
      LOAD: if (last_k) state_nxt = ACC;
      ACC:  if (last_k) state_nxt = SUM;
      SUM:  state_nxt = WR;
      WR:   state_nxt = last_n ? FIN : ACC;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      n       <= '0;
      src     <= '0;
      dst     <= '0;
      len_lat <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src     <= src_base;
            dst     <= dst_base;
            len_lat <= len;
            k       <= '0;
            n       <= '0;
          end
        end
        LOAD: begin
          coef[k] <= $signed(readData);
          k       <= last_k ? '0 : k + 1'b1;
        end
        ACC: begin
          k <= last_k ? '0 : k + 1'b1;
        end
        WR: begin
          n <= n + 8'd1;
          k <= '0;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    addr      = '0;
    writeData = '0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    case (state)
      LOAD: begin
        addr    = COEF_BASE + ADDR_W'(k);
        memRead = 1'b1;
      end
      ACC: begin
        addr    = src + n + ADDR_W'(k);
        memRead = 1'b1;
      end
      WR: begin
        addr      = dst + n;
        writeData = sat8(scaled);
        memWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state == LOAD) || (state == ACC) || (state == SUM) || (state == WR);
  assign done = (state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_fir_mem_master.sv
// ============================================================================
// tb_fir_mem_master : table-driven bench with read/write scoreboards
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fir_mem_master;

  localparam int TAPS      = 4;
  localparam int COEF_BASE = 100;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] src_base;
  logic [7:0] dst_base;
  logic [7:0] len;
  logic [7:0] readData;
  logic [7:0] addr;
  logic [7:0] writeData;
  logic       memWrite;
  logic       memRead;
  logic       busy;
  logic       done;

  fir_mem_master #(
    .TAPS      (TAPS),
    .COEF_BASE (8'(COEF_BASE)),
    .SHIFT     (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .len       (len),
    .readData  (readData),
    .addr      (addr),
    .writeData (writeData),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign readData = mem[addr];

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [5:0][7:0] x;
    logic [7:0]      src;
    logic [7:0]      dst;
    logic [7:0]      len;
    logic [2:0][7:0] y;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c0, c1, c2, c3,
                              input logic [7:0] x0, x1, x2, x3, x4, x5,
                              input logic [7:0] s, d, l,
                              input logic [7:0] y0, y1, y2);
    vec_t v;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3; v.x[4] = x4; v.x[5] = x5;
    v.src = s; v.dst = d; v.len = l;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2;
    return v;
  endfunction

  int          applied;
  int          miscompares;
  int          done_cnt;
  bit          track;
  logic [7:0]  rd_q [$];
  logic [15:0] wr_q [$];

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Memory model and scoreboards: writes land on negedge, reads/writes are popped in order.
  always @(negedge clk) begin
    logic [15:0] e;
    if (memRead && memWrite) check("rd_wr_overlap", 1, 0);
    if (memRead && track) begin
      if (rd_q.size() > 0) check("read_addr", int'(addr), int'(rd_q.pop_front()));
      else                 check("unexpected_read", int'(addr), -1);
    end
    if (memWrite) begin
      mem[addr] = writeData;
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check("write_addr", int'(addr), int'(e[15:8]));
        check("write_data", int'(writeData), int'(e[7:0]));
      end else begin
        check("unexpected_write", int'(addr), -1);
      end
    end
    if (done) done_cnt++;
  end

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < TAPS; i++) mem[8'(COEF_BASE + i)] = v.c[i];
    for (int j = 0; j < 6; j++) mem[8'(v.src + 8'(j))] = v.x[j];
  endtask

  task automatic push_expect(input vec_t v);
    rd_q.delete();
    wr_q.delete();
    if (v.len != 0) begin
      for (int i = 0; i < TAPS; i++) rd_q.push_back(8'(COEF_BASE + i));
    end
    for (int n = 0; n < int'(v.len); n++) begin
      for (int i = 0; i < TAPS; i++) rd_q.push_back(8'(v.src + 8'(n) + 8'(i)));
      wr_q.push_back({8'(v.dst + 8'(n)), v.y[n]});
    end
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #1;
    src_base = v.src; dst_base = v.dst; len = v.len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // restart_at > 0 issues a second start at that cycle of the run, which must be ignored.
  task automatic run_vec(input vec_t v, input int restart_at);
    int c;
    int d0;
    int exp_c;
    load_vec(v);
    push_expect(v);
    d0 = done_cnt;
    pulse_start(v);
    c = 1;
    exp_c = (v.len == 0) ? 1 : TAPS + int'(v.len) * (TAPS + 2) + 1;
    check("busy_after_start", int'(busy), (v.len != 0) ? 1 : 0);
    while (!done && c < 400) begin
      if (c == restart_at) begin
        src_base = 8'd5; dst_base = 8'd250; len = 8'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    check("done_cycle", c, exp_c);
    @(posedge clk); #1;
    check("busy_after_done", int'(busy), 0);
    check("done_width", int'(done), 0);
    check("queues_drained", rd_q.size() + wr_q.size(), 0);
    check("done_count", done_cnt - d0, 1);
    for (int n = 0; n < int'(v.len); n++) begin
      check("mem_result", int'(mem[8'(v.dst + 8'(n))]), int'(v.y[n]));
    end
  endtask

  vec_t vecs [7];

  initial begin
    applied     = 0;
    miscompares = 0;
    done_cnt    = 0;
    track       = 1'b1;
    start       = 1'b0;
    src_base    = '0;
    dst_base    = '0;
    len         = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = mk(8'h40, 8'h40, 8'h00, 8'h00, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0,
                 8'd50, 8'd150, 8'd3, 8'd15, 8'd25, 8'd35);
    vecs[1] = mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                 8'd10, 8'd200, 8'd1, 8'h7F, 8'h00, 8'h00);
    vecs[2] = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                 8'd30, 8'd201, 8'd1, 8'h80, 8'h00, 8'h00);
    vecs[3] = mk(8'h80, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                 8'd40, 8'd202, 8'd1, 8'h81, 8'h00, 8'h00);
    vecs[4] = mk(8'h40, 8'h40, 8'h40, 8'h40, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0,
                 8'hFE, 8'd160, 8'd2, 8'd5, 8'd7, 8'h00);
    vecs[5] = mk(8'h40, 8'hC0, 8'h20, 8'h00, 8'd100, 8'd50, 8'hEC, 8'd0, 8'd0, 8'd0,
                 8'd20, 8'd170, 8'd1, 8'd20, 8'h00, 8'h00);
    vecs[6] = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9,
                 8'd60, 8'd180, 8'd0, 8'h00, 8'h00, 8'h00);

    rst = 1'b1;
    #1;
    check("rst_addr", int'(addr), 0);
    check("rst_memwrite", int'(memWrite), 0);
    check("rst_memread", int'(memRead), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0);

    // Second start mid-run must not be accepted.
    run_vec(vecs[0], 5);
    repeat (20) @(posedge clk);
    #1 check("no_late_done", int'(done), 0);

    // Reset during the second write cycle: no write, no done, clean restart.
    for (int i = 150; i < 153; i++) mem[i] = 8'h5A;
    load_vec(vecs[0]);
    rd_q.delete();
    wr_q.delete();
    wr_q.push_back({8'd150, 8'd15});
    track = 1'b0;
    begin
      int d0;
      d0 = done_cnt;
      pulse_start(vecs[0]);
      repeat (15) @(posedge clk);
      #1;
      check("second_wr_strobe", int'(memWrite), 1);
      check("second_wr_addr", int'(addr), 151);
      #2 rst = 1'b1;
      #1;
      check("rst_drops_memwrite", int'(memWrite), 0);
      check("rst_drops_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("rst_first_kept", int'(mem[150]), 15);
      check("rst_second_untouched", int'(mem[151]), 8'h5A);
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_wr_queue", wr_q.size(), 0);
    end
    track = 1'b1;
    run_vec(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
